arb_mux: RTL and testbench

//   Parametrised N:1 datapath selector with a registered, valid/ready-handshaked output.

---
 rtl/arb_mux_if.sv | 37 +++
 rtl/arb_mux.sv | 135 +++++++++++++
 tb/tb_arb_mux.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/arb_mux_if.sv
// arb_mux_if: handshake/data bundle for arb_mux.
//   in_data   N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid  N        per-channel valid
//   in_ready  N        per-channel ready, at most one bit high
//   sel       SEL_W    external channel select (MODE=0 only)
//   flush     1        discard output stage
//   out_data  WIDTH    registered data
//   out_src   SEL_W    channel that supplied out_data
//   out_valid 1        output stage holds data
//   out_ready 1        consumer accepts out_data
// master = producers/consumer side, slave = arb_mux.
interface arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 8
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SEL_W-1:0]   sel;
  logic               flush;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_src;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, sel, flush, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, flush, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/arb_mux.sv
// arb_mux: N:1 selector with a one-entry registered valid/ready output stage.
//   MODE=0: channel picked by bus.sel (sel >= N grants nothing).
//   MODE=1: round-robin over in_valid starting at ptr; ptr moves past the winner.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      arb_mux_if.slave (input channels, select, flush, output stage)
//   xfer_cnt saturating count of output transfers (only with ARB_MUX_STATS_EN)
// Optional feature macro: ARB_MUX_STATS_EN adds the xfer_cnt port and counter.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int MODE  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  arb_mux_if.slave    bus
`ifdef ARB_MUX_STATS_EN
  ,
  output logic [15:0] xfer_cnt
`endif
);
  localparam int             SEL_W = (N > 1) ? $clog2(N) : 1;
  localparam int             NP    = 1 << SEL_W;
  localparam logic [SEL_W:0] N_W   = (SEL_W+1)'(N);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] c;
  logic             hit, load_en, gnt;
  logic [WIDTH-1:0] c_data;
  logic [NP-1:0]    vld_pad;
  logic [N-1:0]     rot;
  logic [SEL_W:0]   idx, nxt;
  logic [N-1:0]     rdy;

  // Channel choice. In RR mode in_valid is rotated so bit k is channel
  // (ptr+k) mod N; scanning k downwards lets the lowest k win.
  always_comb begin
    c       = '0;
    hit     = 1'b0;
    idx     = '0;
    vld_pad = NP'(bus.in_valid);
    rot     = N'({bus.in_valid, bus.in_valid} >> ptr_q);
    if (MODE == 0) begin
      c   = bus.sel;
      hit = ({1'b0, bus.sel} < N_W) && vld_pad[bus.sel];
    end else begin
      for (int k = N-1; k >= 0; k--) begin
        if (rot[k]) begin
          idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
          if (idx >= N_W) idx = idx - N_W;
          c   = idx[SEL_W-1:0];
          hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    c_data = '0;
    for (int i = 0; i < N; i++)
      if (c == SEL_W'(i)) c_data = bus.in_data[i*WIDTH +: WIDTH];
  end

  // Stage can accept when empty or draining this cycle; flush blocks loads.
  assign load_en = ((state_q == S_EMPTY) || bus.out_ready) && !bus.flush;
  assign gnt     = load_en && hit;

  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign rdy[i] = gnt && (c == SEL_W'(i));
  end
  assign bus.in_ready = rdy;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    nxt     = {1'b0, c} + (SEL_W+1)'(1);
    if (bus.flush) begin
      state_d = S_EMPTY;
    end else if (gnt) begin
      state_d = S_FULL;
      data_d  = c_data;
      src_d   = c;
      // Explicit wrap so non-power-of-two N never reaches ptr >= N.
      if (MODE != 0) ptr_d = (nxt >= N_W) ? '0 : nxt[SEL_W-1:0];
    end else if (bus.out_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out_valid = (state_q == S_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

`ifdef ARB_MUX_STATS_EN
  // Counts consumer handshakes, including one coinciding with flush.
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_FULL) && bus.out_ready && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_arb_mux.sv
module tb_arb_mux;
  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  arb_mux_if #(.WIDTH(32), .N(8)) if8 ();
  arb_mux_if #(.WIDTH(32), .N(6)) if6 ();
  arb_mux_if #(.WIDTH(32), .N(4)) if4 ();

`ifdef ARB_MUX_STATS_EN
  logic [15:0] cnt8, cnt6, cnt4;
`endif

  arb_mux #(.WIDTH(32), .N(8), .MODE(0)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave)
`ifdef ARB_MUX_STATS_EN
    , .xfer_cnt(cnt8)
`endif
  );

  arb_mux #(.WIDTH(32), .N(6), .MODE(0)) u6 (
    .clk(clk), .rst_n(rst_n), .bus(if6.slave)
`ifdef ARB_MUX_STATS_EN
    , .xfer_cnt(cnt6)
`endif
  );

  arb_mux #(.WIDTH(32), .N(4), .MODE(1)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave)
`ifdef ARB_MUX_STATS_EN
    , .xfer_cnt(cnt4)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    if8.in_valid = '0; if8.sel = '0; if8.flush = 1'b0; if8.out_ready = 1'b0;
    if6.in_valid = '0; if6.sel = '0; if6.flush = 1'b0; if6.out_ready = 1'b0;
    if4.in_valid = '0; if4.sel = '0; if4.flush = 1'b0; if4.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) if8.in_data[i*32 +: 32] = 32'h1000_0000 + i;
    for (int i = 0; i < 6; i++) if6.in_data[i*32 +: 32] = 32'h6000_0000 + i;
    for (int i = 0; i < 4; i++) if4.in_data[i*32 +: 32] = 32'h4000_0000 + i;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (if8.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid8 got %0b want 0", if8.out_valid); end
    nvec++; if (if8.out_data !== 32'h0) begin nerr++; $display("FAIL reset_data8 got %h want 0", if8.out_data); end
    nvec++; if (if8.out_src !== 3'd0) begin nerr++; $display("FAIL reset_src8 got %0d want 0", if8.out_src); end
    nvec++; if (if4.out_valid !== 1'b0 || if6.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid46 got %0b%0b want 00", if4.out_valid, if6.out_valid); end
    nvec++; if (if8.in_ready !== 8'h00) begin nerr++; $display("FAIL reset_ready8 got %b want 0", if8.in_ready); end
`ifdef ARB_MUX_STATS_EN
    nvec++; if (cnt8 !== 16'd0) begin nerr++; $display("FAIL reset_cnt got %0d want 0", cnt8); end
`endif
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_sel;
    if8.in_valid = 8'hFF;
    if8.out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      if8.sel = 3'(s);
      #1;
      nvec++; if (if8.in_ready !== 8'(1 << s)) begin nerr++; $display("FAIL sel_ready[%0d] got %b want %b", s, if8.in_ready, 8'(1 << s)); end
      step;
      nvec++; if (if8.out_data !== 32'h1000_0000 + s) begin nerr++; $display("FAIL sel_data[%0d] got %h want %h", s, if8.out_data, 32'h1000_0000 + s); end
      nvec++; if (if8.out_src !== 3'(s) || if8.out_valid !== 1'b1) begin nerr++; $display("FAIL sel_src[%0d] got %0d/%0b want %0d/1", s, if8.out_src, if8.out_valid, s); end
    end
    if8.in_valid = '0;
    step;
    nvec++; if (if8.out_valid !== 1'b0) begin nerr++; $display("FAIL sel_drain got %0b want 0", if8.out_valid); end
    nvec++; if (if8.out_data !== 32'h1000_0007) begin nerr++; $display("FAIL sel_hold got %h want 10000007", if8.out_data); end
  endtask

  task automatic test_bad_sel;
    if6.in_valid = 6'h3F;
    if6.out_ready = 1'b1;
    for (int v = 6; v < 8; v++) begin
      if6.sel = 3'(v);
      #1;
      nvec++; if (if6.in_ready !== 6'h00) begin nerr++; $display("FAIL badsel_ready[%0d] got %b want 0", v, if6.in_ready); end
      step;
      nvec++; if (if6.out_valid !== 1'b0) begin nerr++; $display("FAIL badsel_valid[%0d] got %0b want 0", v, if6.out_valid); end
    end
    if6.sel = 3'd5;
    #1;
    nvec++; if (if6.in_ready !== 6'b100000) begin nerr++; $display("FAIL sel5_ready got %b want 100000", if6.in_ready); end
    step;
    nvec++; if (if6.out_src !== 3'd5 || if6.out_data !== 32'h6000_0005) begin nerr++; $display("FAIL sel5_out got %0d/%h want 5/60000005", if6.out_src, if6.out_data); end
    if6.in_valid = '0;
    step;
  endtask

  task automatic test_rr;
    if4.in_valid = 4'hF;
    if4.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step;
      nvec++; if (if4.out_src !== 2'(k % 4) || if4.out_data !== 32'h4000_0000 + (k % 4)) begin nerr++; $display("FAIL rr_all[%0d] got %0d/%h want %0d", k, if4.out_src, if4.out_data, k % 4); end
    end
    if4.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step;
      nvec++; if (if4.out_src !== ((k % 2 == 0) ? 2'd1 : 2'd3)) begin nerr++; $display("FAIL rr_1010[%0d] got %0d want %0d", k, if4.out_src, (k % 2 == 0) ? 1 : 3); end
    end
    if4.in_valid = '0;
    step;
    nvec++; if (if4.out_valid !== 1'b0) begin nerr++; $display("FAIL rr_drain got %0b want 0", if4.out_valid); end
  endtask

  task automatic test_back_to_back;
    if8.in_valid = 8'hFF;
    if8.sel = 3'd2;
    if8.out_ready = 1'b1;
    step;
    if8.out_ready = 1'b0;
    if8.sel = 3'd5;
    for (int k = 0; k < 5; k++) begin
      #1;
      nvec++; if (if8.in_ready !== 8'h00) begin nerr++; $display("FAIL bp_ready[%0d] got %b want 0", k, if8.in_ready); end
      step;
      nvec++; if (if8.out_data !== 32'h1000_0002 || if8.out_src !== 3'd2 || if8.out_valid !== 1'b1) begin nerr++; $display("FAIL bp_hold[%0d] got %h/%0d/%0b want 10000002/2/1", k, if8.out_data, if8.out_src, if8.out_valid); end
    end
    if8.out_ready = 1'b1;
    #1;
    nvec++; if (if8.in_ready !== 8'h20) begin nerr++; $display("FAIL bp_release got %b want 00100000", if8.in_ready); end
    step;
    nvec++; if (if8.out_data !== 32'h1000_0005 || if8.out_valid !== 1'b1) begin nerr++; $display("FAIL b2b_first got %h/%0b want 10000005/1", if8.out_data, if8.out_valid); end
    if8.sel = 3'd6;
    step;
    nvec++; if (if8.out_data !== 32'h1000_0006 || if8.out_valid !== 1'b1) begin nerr++; $display("FAIL b2b_second got %h/%0b want 10000006/1", if8.out_data, if8.out_valid); end
    if8.in_valid = '0;
    step;
    nvec++; if (if8.out_valid !== 1'b0) begin nerr++; $display("FAIL b2b_drain got %0b want 0", if8.out_valid); end
  endtask

  task automatic test_flush;
    // ptr of u4 is 0 here
    if4.in_valid = 4'b0100;
    if4.out_ready = 1'b0;
    step;
    nvec++; if (if4.out_src !== 2'd2 || if4.out_valid !== 1'b1) begin nerr++; $display("FAIL fl_load got %0d/%0b want 2/1", if4.out_src, if4.out_valid); end
    if4.flush = 1'b1;
    if4.in_valid = 4'b0001;
    if4.out_ready = 1'b1;
    #1;
    nvec++; if (if4.in_ready !== 4'b0000) begin nerr++; $display("FAIL fl_ready_full got %b want 0", if4.in_ready); end
    step;
    nvec++; if (if4.out_valid !== 1'b0) begin nerr++; $display("FAIL fl_valid got %0b want 0", if4.out_valid); end
    nvec++; if (if4.out_data !== 32'h4000_0002) begin nerr++; $display("FAIL fl_data got %h want 40000002", if4.out_data); end
    nvec++; if (if4.in_ready !== 4'b0000) begin nerr++; $display("FAIL fl_ready_empty got %b want 0", if4.in_ready); end
    if4.flush = 1'b0;
    if4.in_valid = 4'b0011;
    #1;
    // ptr stayed at 3, so the scan 3,0,.. picks channel 0
    nvec++; if (if4.in_ready !== 4'b0001) begin nerr++; $display("FAIL fl_ptr got %b want 0001", if4.in_ready); end
    step;
    nvec++; if (if4.out_src !== 2'd0 || if4.out_valid !== 1'b1) begin nerr++; $display("FAIL fl_after got %0d/%0b want 0/1", if4.out_src, if4.out_valid); end
    if4.in_valid = '0;
    step;
  endtask

  task automatic test_async_reset;
    if8.in_valid = 8'hFF;
    if8.sel = 3'd1;
    if8.out_ready = 1'b1;
    step;
    nvec++; if (if8.out_valid !== 1'b1 || if8.out_data !== 32'h1000_0001) begin nerr++; $display("FAIL ar_load got %0b/%h want 1/10000001", if8.out_valid, if8.out_data); end
    if8.in_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    nvec++; if (if8.out_valid !== 1'b0 || if8.out_data !== 32'h0) begin nerr++; $display("FAIL ar_clear got %0b/%h want 0/0", if8.out_valid, if8.out_data); end
    #2;
    rst_n = 1'b1;
    step;
  endtask

`ifdef ARB_MUX_STATS_EN
  task automatic test_stats;
    nvec++; if (cnt8 !== 16'd0) begin nerr++; $display("FAIL st_start got %0d want 0", cnt8); end
    if8.in_valid = 8'hFF;
    if8.sel = 3'd0;
    if8.out_ready = 1'b1;
    repeat (101) step;
    nvec++; if (cnt8 !== 16'd100) begin nerr++; $display("FAIL st_100 got %0d want 100", cnt8); end
    repeat (70000) step;
    nvec++; if (cnt8 !== 16'hFFFF) begin nerr++; $display("FAIL st_sat got %h want ffff", cnt8); end
    if8.flush = 1'b1;
    step;
    if8.flush = 1'b0;
    step;
    nvec++; if (cnt8 !== 16'hFFFF) begin nerr++; $display("FAIL st_flush got %h want ffff", cnt8); end
    if8.in_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    nvec++; if (cnt8 !== 16'd0) begin nerr++; $display("FAIL st_reset got %0d want 0", cnt8); end
    rst_n = 1'b1;
    step;
  endtask
`endif

  initial begin
    test_reset;
    test_sel;
    test_bad_sel;
    test_rr;
    test_back_to_back;
    test_flush;
    test_async_reset;
`ifdef ARB_MUX_STATS_EN
    test_stats;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
